// File: rtl/ysyx_22040931_ifu_pcgen_if.sv
// rtl/ysyx_22040931_ifu_pcgen_if.sv - fetch-side bus: redirect, imem request/response, decode buffer
interface ysyx_22040931_ifu_pcgen_if #(
    parameter int XLEN = 64
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_inst;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_inst;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_inst,
        output if_valid, if_pc, if_inst,
        input  if_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_inst,
        input  if_valid, if_pc, if_inst,
        output if_ready
    );
endinterface

// File: rtl/ysyx_22040931_ifu_pcgen.sv
// rtl/ysyx_22040931_ifu_pcgen.sv - fetch PC generator with one outstanding imem request and a single-entry decode buffer
module ysyx_22040931_ifu_pcgen #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_22040931_ifu_pcgen_if.master     bus
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            free;
    logic            req_valid;
    logic            req_fire;
    logic            load;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] redirect_aligned;

    assign free             = !bus.if_valid || bus.if_ready;
    assign redirect_aligned = bus.redirect_pc & ~XLEN'(3);
    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // A redirect while waiting turns the in-flight fetch into one to be discarded.
    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ: begin
                if (req_fire) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.imem_resp_valid)     state_nxt = S_REQ;
                else if (bus.redirect_valid) state_nxt = S_DROP;
            end
            S_DROP: begin
                if (bus.imem_resp_valid) state_nxt = S_REQ;
            end
            default: state_nxt = S_REQ;
        endcase
    end

    always_comb begin
        req_valid = !rst && (state == S_REQ) && free && !bus.redirect_valid;
        req_fire  = req_valid && bus.imem_req_ready;
        load      = (state == S_WAIT) && bus.imem_resp_valid && !bus.redirect_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            bus.if_valid <= 1'b0;
            bus.if_pc    <= '0;
            bus.if_inst  <= '0;
        end else begin
            if (bus.redirect_valid) pc <= redirect_aligned;
            else if (load)          pc <= pc + XLEN'(4);

            // Redirect flushes the buffer even when decode is consuming it this cycle.
            if (bus.redirect_valid) bus.if_valid <= 1'b0;
            else if (load)          bus.if_valid <= 1'b1;
            else if (bus.if_ready)  bus.if_valid <= 1'b0;

            if (load) begin
                bus.if_pc   <= pc;
                bus.if_inst <= bus.imem_resp_inst;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040931_ifu_pcgen.sv
// tb/tb_ysyx_22040931_ifu_pcgen.sv - directed vector table plus randomized run against a transaction-level model
module tb_ysyx_22040931_ifu_pcgen;

    localparam logic [63:0] RP = 64'h0000_0000_8000_0000;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [63:0] rpc;
        logic        rrdy;
        logic        resp;
        logic [31:0] inst;
        logic        ifr;
        logic        e_rv;
        logic [63:0] e_addr;
        logic        e_ifv;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ysyx_22040931_ifu_pcgen_if #(.XLEN(64)) ifc();

    ysyx_22040931_ifu_pcgen #(.XLEN(64), .RESET_PC(RP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic redir, input logic [63:0] rpc, input logic rrdy,
                         input logic resp, input logic [31:0] inst, input logic ifr);
        rst                 = r;
        ifc.redirect_valid  = redir;
        ifc.redirect_pc     = rpc;
        ifc.imem_req_ready  = rrdy;
        ifc.imem_resp_valid = resp;
        ifc.imem_resp_inst  = inst;
        ifc.if_ready        = ifr;
    endtask

    function automatic vec_t mk(input logic r, input logic redir, input logic [63:0] rpc, input logic rrdy,
                                input logic resp, input logic [31:0] inst, input logic ifr,
                                input logic e_rv, input logic [63:0] e_addr,
                                input logic e_ifv, input logic [63:0] e_pc, input logic [31:0] e_inst);
        vec_t v;
        v.rst = r; v.redir = redir; v.rpc = rpc; v.rrdy = rrdy;
        v.resp = resp; v.inst = inst; v.ifr = ifr;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_ifv = e_ifv; v.e_pc = e_pc; v.e_inst = e_inst;
        return v;
    endfunction

    function automatic logic [31:0] mem_inst(input logic [63:0] a);
        return a[33:2] ^ 32'h5A17_C3E9;
    endfunction

    // transaction-level reference: pc, one outstanding fetch (maybe doomed), one buffered instruction
    logic [63:0] m_pc;
    logic        m_out;
    logic        m_disc;
    logic        m_bv;
    logic [63:0] m_bpc;
    logic [31:0] m_binst;

    vec_t        tbl[$];
    int unsigned due[$];
    logic [63:0] maddr[$];

    logic        r_r, r_redir, r_rrdy, r_resp, r_ifr, e_rv, got;
    logic [63:0] r_rpc, d_addr;
    logic [31:0] r_inst;
    int unsigned d;

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 32'd0, 1'b1);

        @(negedge clk);
        #1;
        chk("reset imem_req_valid", {63'd0, ifc.imem_req_valid}, 64'd0);
        chk("reset if_valid",       {63'd0, ifc.if_valid},       64'd0);
        chk("reset if_pc",          ifc.if_pc,                   64'd0);
        chk("reset if_inst",        {32'd0, ifc.if_inst},        64'd0);

        tbl.push_back(mk(0,0,0,1,0,32'h0,1,            1,RP,        0,0,0));
        tbl.push_back(mk(0,0,0,1,1,32'h1111_0001,1,    0,0,         0,0,0));
        tbl.push_back(mk(0,0,0,1,0,32'h0,1,            1,RP+4,      1,RP,32'h1111_0001));
        tbl.push_back(mk(0,0,0,1,1,32'h1111_0002,1,    0,0,         0,0,0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,0,0,1,0,32'h0,0,        0,0,         1,RP+4,32'h1111_0002));
        tbl.push_back(mk(0,0,0,1,0,32'h0,1,            1,RP+8,      1,RP+4,32'h1111_0002));
        tbl.push_back(mk(0,0,0,1,1,32'h1111_0003,1,    0,0,         0,0,0));
        tbl.push_back(mk(0,0,0,1,0,32'h0,1,            1,RP+12,     1,RP+8,32'h1111_0003));
        tbl.push_back(mk(0,1,64'h8000_1002,1,0,32'h0,1, 0,0,        0,0,0));
        tbl.push_back(mk(0,0,0,1,0,32'h0,1,            0,0,         0,0,0));
        tbl.push_back(mk(0,0,0,1,1,32'hDEAD_0001,1,    0,0,         0,0,0));
        tbl.push_back(mk(0,0,0,1,0,32'h0,1,            1,64'h8000_1000, 0,0,0));
        tbl.push_back(mk(0,1,64'h8000_2000,1,1,32'hDEAD_0002,1, 0,0, 0,0,0));
        tbl.push_back(mk(0,0,0,1,0,32'h0,1,            1,64'h8000_2000, 0,0,0));
        tbl.push_back(mk(0,0,0,1,1,32'h2222_0001,1,    0,0,         0,0,0));
        tbl.push_back(mk(0,1,64'h8000_3000,1,0,32'h0,1, 0,0,        1,64'h8000_2000,32'h2222_0001));
        tbl.push_back(mk(0,0,0,1,0,32'h0,1,            1,64'h8000_3000, 0,0,0));
        tbl.push_back(mk(1,0,0,1,0,32'h0,1,            0,0,         0,0,0));
        tbl.push_back(mk(0,0,0,1,1,32'hDEAD_0003,1,    1,RP,        0,0,0));
        tbl.push_back(mk(0,0,0,1,1,32'h3333_0001,1,    0,0,         0,0,0));
        tbl.push_back(mk(0,0,0,1,0,32'h0,1,            1,RP+4,      1,RP,32'h3333_0001));
        tbl.push_back(mk(0,0,0,1,1,32'h3333_0002,1,    0,0,         0,0,0));
        tbl.push_back(mk(0,1,64'hFFFF_FFFF_FFFF_FFFF,1,0,32'h0,1, 0,0, 1,RP+4,32'h3333_0002));
        tbl.push_back(mk(0,0,0,1,0,32'h0,1,            1,64'hFFFF_FFFF_FFFF_FFFC, 0,0,0));
        tbl.push_back(mk(0,0,0,1,1,32'h4444_0001,1,    0,0,         0,0,0));
        tbl.push_back(mk(0,0,0,1,0,32'h0,1,            1,64'd0,     1,64'hFFFF_FFFF_FFFF_FFFC,32'h4444_0001));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].rrdy, tbl[i].resp, tbl[i].inst, tbl[i].ifr);
            #1;
            chk($sformatf("vec%0d imem_req_valid", i), {63'd0, ifc.imem_req_valid}, {63'd0, tbl[i].e_rv});
            if (tbl[i].e_rv)
                chk($sformatf("vec%0d imem_req_addr", i), ifc.imem_req_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d if_valid", i), {63'd0, ifc.if_valid}, {63'd0, tbl[i].e_ifv});
            if (tbl[i].e_ifv) begin
                chk($sformatf("vec%0d if_pc", i), ifc.if_pc, tbl[i].e_pc);
                chk($sformatf("vec%0d if_inst", i), {32'd0, ifc.if_inst}, {32'd0, tbl[i].e_inst});
            end
        end

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r_r     = (c == 0) || ($urandom_range(0, 199) == 0);
            r_redir = !r_r && ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       r_rpc = {$urandom, $urandom};
                1:       r_rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
                default: r_rpc = RP + 64'($urandom_range(0, 4095));
            endcase
            r_ifr  = ($urandom_range(0, 9) < 7);
            r_rrdy = ($urandom_range(0, 9) < 7);
            r_inst = $urandom;
            if (r_r) begin
                due.delete();
                maddr.delete();
            end
            r_resp = !r_r && (due.size() > 0) && (due[0] == c);
            if (r_resp) begin
                r_inst = mem_inst(maddr[0]);
                void'(due.pop_front());
                void'(maddr.pop_front());
            end
            drive(r_r, r_redir, r_rpc, r_rrdy, r_resp, r_inst, r_ifr);
            #1;

            e_rv = !r_r && !m_out && (!m_bv || r_ifr) && !r_redir;
            chk($sformatf("rnd%0d imem_req_valid", c), {63'd0, ifc.imem_req_valid}, {63'd0, e_rv});
            if (e_rv)
                chk($sformatf("rnd%0d imem_req_addr", c), ifc.imem_req_addr, m_pc);
            chk($sformatf("rnd%0d if_valid", c), {63'd0, ifc.if_valid}, {63'd0, m_bv});
            if (m_bv) begin
                chk($sformatf("rnd%0d if_pc", c), ifc.if_pc, m_bpc);
                chk($sformatf("rnd%0d if_inst", c), {32'd0, ifc.if_inst}, {32'd0, m_binst});
            end

            if (ifc.imem_req_valid && r_rrdy) begin
                d_addr = ifc.imem_req_addr;
                d = c + $urandom_range(1, 3);
                if (due.size() > 0 && due[$] >= d) d = due[$] + 1;
                due.push_back(d);
                maddr.push_back(d_addr);
            end

            if (r_r) begin
                m_pc = RP; m_out = 0; m_disc = 0; m_bv = 0;
            end else begin
                got = 0;
                if (r_resp && m_out) begin
                    got = !m_disc;
                    m_out = 0;
                    m_disc = 0;
                end
                if (r_redir) begin
                    m_bv = 0;
                    m_pc = r_rpc & ~64'd3;
                    if (m_out) m_disc = 1;
                end else if (got) begin
                    m_bv = 1; m_bpc = m_pc; m_binst = r_inst; m_pc = m_pc + 64'd4;
                end else if (r_ifr) begin
                    m_bv = 0;
                end
                if (e_rv && r_rrdy) begin
                    m_out = 1;
                    m_disc = 0;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22040931_ifu_pcgen.md
Name: ysyx_22040931_ifu_pcgen

Overview:
Instruction-fetch PC generator and fetch buffer for the 64-bit core. It sits directly upstream of decode/branch resolution. It holds the architectural fetch PC and issues one outstanding instruction-memory request at a time. It presents fetched instructions to decode through a valid/ready handshake. It consumes the branch unit's taken-jump result as a redirect, which flushes wrong-path fetches.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset
XLEN, 64, PC/address width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
redirect_valid  input  1  taken branch/jump from the branch stage; single-cycle pulse
redirect_pc  input  XLEN  redirect target
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts the request this cycle
imem_req_addr  output  XLEN  fetch address
imem_resp_valid  input  1  fetch response valid; exactly one per accepted request; earliest one cycle after acceptance
imem_resp_inst  input  32  fetched instruction
if_valid  output  1  instruction buffer valid toward decode
if_ready  input  1  decode consumes the buffer this cycle
if_pc  output  XLEN  PC of the buffered instruction
if_inst  output  32  buffered instruction

Behaviour:
- Registered state: pc, state ∈ {REQ, WAIT, DROP}, buffer (if_valid, if_pc, if_inst).
- Reset (rst=1 at an edge):
  - pc=RESET_PC, state=REQ, if_valid=0, if_pc=0, if_inst=0.
  - imem_req_valid=0 during any cycle with rst=1.
  - Any response arriving while state=REQ is ignored; this covers reset during an outstanding fetch.
- Buffer free condition: free = !if_valid || if_ready.
- REQ:
  - imem_req_valid = free && !redirect_valid; imem_req_addr = pc; both are combinational.
  - On valid && ready, go to WAIT.
- WAIT:
  - imem_req_valid=0.
  - On imem_resp_valid: load buffer with if_valid=1, if_pc=pc, if_inst=imem_resp_inst; set pc=pc+4 (wraps mod 2^64); go to REQ.
  - The buffer is guaranteed free here, because a request is only issued when free and decode holds no second entry.
- Buffer handshake:
  - if_valid && if_ready with no new load clears if_valid.
  - if_pc/if_inst hold stable while if_valid && !if_ready.
- Redirect (highest priority, evaluated each cycle):
  - pc = {redirect_pc[63:2], 2'b00}; if_valid=0 (the buffered instruction is flushed even if if_ready=1 the same cycle).
  - State = REQ, if none is outstanding.
  - State = DROP, if in WAIT without a response this cycle.
  - A response arriving in the same cycle is discarded and state = REQ.
  - Because imem_req_valid is suppressed during redirect, no wrong-path request is issued in the redirect cycle.
- DROP:
  - imem_req_valid=0.
  - The next imem_resp_valid is discarded (no buffer load, pc unchanged); go to REQ.
  - A redirect in DROP updates pc and stays in DROP.
- Latency: request accepted at cycle N, response at N+k; if_valid is high at N+k+1; the next request can be issued at N+k+1.
- Throughput: at most one instruction per 2 cycles with a 1-cycle memory.
- Redirect-to-new-request: a redirect in cycle N with no outstanding fetch gives imem_req_valid=1 with the new address in cycle N+1.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle response, if_ready=1: requests at 0x80000000, 0x80000004, 0x80000008; if_pc follows the same sequence with matching if_inst.
- if_ready=0 for 5 cycles with the buffer full: if_pc/if_inst stable, imem_req_valid=0 throughout; the next request follows if_ready=1.
- Redirect to 0x80001002 while in WAIT, response 2 cycles later: that response is dropped, the next request address is 0x80001000, and no if_valid is produced for the old PC.
- Redirect in the same cycle as imem_resp_valid: the instruction is not buffered, and the next cycle's request goes to the redirect target.
- Redirect while if_valid=1 and if_ready=1: if_valid=0 next cycle and the stale instruction is not re-presented.
- rst asserted during WAIT, stale response delivered 1 cycle after reset release: the response is ignored; the first if_pc is 0x80000000 with the correct instruction.
- pc=64'hFFFF_FFFF_FFFF_FFFC fetched: the next request wraps to address 0.
